instr_mem_loadable: RTL and testbench

- Parametrised, synchronous-read instruction memory for the pipelined MIPS core; it replaces the hard-coded combinational program ROM.
- Has a fetch port with a one-cycle read latency and a stall hold.
- Has a byte-serial load port so a program can be written at run time (UART bootloader). A load FSM packs the bytes into words.
- Fetches outside the memory window, and misaligned fetches, return a configurable default instruction and an error flag.

---
 rtl/instr_mem_loadable.sv | 114 +++++++++++
 tb/tb_instr_mem_loadable.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: synchronous-read instruction memory with a byte-serial load port.
module instr_mem_loadable #(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [31:0]           BASE_ADDR     = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_INSTR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  input  logic                  fetch_stall,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  fetch_err,
  input  logic                  load_en,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_words,
  output logic                  busy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;
  state_t                  r_state;
  logic                    r_need_low;
  logic [ADDR_WIDTH:0]     r_ptr;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_asm;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [31:0]             w_off;
  logic                    w_in_range;
  logic                    w_go_load;
  logic                    w_we;
  logic                    w_last;
  logic [DATA_WIDTH+7:0]   w_shift;
  logic [DATA_WIDTH-1:0]   w_word;
  assign w_off      = (fetch_addr - BASE_ADDR) >> 2;
  assign w_in_range = w_off < 32'(DEPTH) && fetch_addr[1:0] == 2'b00;
  // r_need_low blocks re-entry after a full-memory load until load_en is seen low
  assign w_go_load  = r_state == RUN && load_en && !r_need_low;
  assign w_shift    = {r_asm, load_byte};
  assign w_word     = w_shift[DATA_WIDTH-1:0];
  assign w_we       = r_state == LOAD && load_en && load_byte_valid && r_cnt == CW'(BPW - 1);
  assign w_last     = r_ptr == (ADDR_WIDTH + 1)'(DEPTH - 1);
  assign busy       = r_state != RUN;
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr[ADDR_WIDTH-1:0]] <= w_word;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_need_low  <= 1'b0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_asm       <= '0;
      instr       <= DEFAULT_INSTR;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      load_done   <= 1'b0;
      load_words  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          load_done <= 1'b0;
          if (!load_en) r_need_low <= 1'b0;
          if (w_go_load) begin
            r_state     <= LOAD;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_asm       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
          end else if (!fetch_stall) begin
            instr_valid <= fetch_req;
            if (fetch_req) begin
              instr     <= w_in_range ? r_mem[w_off[ADDR_WIDTH-1:0]] : DEFAULT_INSTR;
              fetch_err <= !w_in_range;
            end
          end
        end
        LOAD: begin
          if (!load_en) begin
            r_state    <= DONE;
            load_done  <= 1'b1;
            load_words <= r_ptr;
          end else if (load_byte_valid) begin
            if (w_we) begin
              r_ptr <= r_ptr + 1'b1;
              r_cnt <= '0;
              r_asm <= '0;
              if (w_last) begin
                r_state    <= DONE;
                load_done  <= 1'b1;
                load_words <= r_ptr + 1'b1;
                r_need_low <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_asm <= w_word;
            end
          end
        end
        DONE: begin
          r_state   <= RUN;
          load_done <= 1'b0;
        end
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: randomized bench against a transaction-level memory model.
module tb_instr_mem_loadable;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_stall;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          fetch_err;
  logic          load_en;
  logic          load_byte_valid;
  logic [7:0]    load_byte;
  logic          load_done;
  logic [AW:0]   load_words;
  logic          busy;
  instr_mem_loadable #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .instr(instr), .instr_valid(instr_valid),
    .fetch_err(fetch_err), .load_en(load_en), .load_byte_valid(load_byte_valid),
    .load_byte(load_byte), .load_done(load_done), .load_words(load_words), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [31:0] mm [DEPTH];
  logic [31:0] e_instr;
  logic        e_valid;
  logic        e_err;
  int          e_words;
  logic [7:0]  bq [$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_outs(input string tag);
    check({tag, "/instr"}, 64'(instr), 64'(e_instr));
    check({tag, "/valid"}, 64'(instr_valid), 64'(e_valid));
    check({tag, "/err"}, 64'(fetch_err), 64'(e_err));
  endtask
  task automatic cyc(input logic req, input logic stall, input logic [31:0] addr);
    logic [31:0] off;
    logic        inr;
    fetch_req = req;
    fetch_stall = stall;
    fetch_addr = addr;
    @(negedge clk);
    if (!stall) begin
      if (req) begin
        off = addr >> 2;
        inr = off < DEPTH && addr % 4 == 0;
        e_instr = inr ? mm[off[7:0]] : 32'h0;
        e_err = !inr;
        e_valid = 1'b1;
      end else e_valid = 1'b0;
    end
    check_outs("fetch");
    check("fetch/busy", 64'(busy), 64'(0));
  endtask
  task automatic run_load(input bit gaps);
    int          w = 0;
    int          n = 0;
    logic [31:0] acc = 0;
    bit          full = 0;
    fetch_req = 0;
    fetch_stall = 0;
    load_en = 1;
    load_byte_valid = 0;
    @(negedge clk);
    e_valid = 0;
    e_err = 0;
    check("load/busy_enter", 64'(busy), 64'(1));
    check_outs("load/enter");
    for (int i = 0; i < bq.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        load_byte_valid = 0;
        @(negedge clk);
      end
      load_byte_valid = 1;
      load_byte = bq[i];
      @(negedge clk);
      acc = (acc << 8) | 32'(bq[i]);
      n++;
      if (n == 4) begin
        mm[w] = acc;
        w++;
        n = 0;
        acc = 0;
      end
      if (w == DEPTH) begin
        full = 1;
        break;
      end
    end
    load_byte_valid = 0;
    if (!full) begin
      load_en = 0;
      @(negedge clk);
    end
    e_words = w;
    check("load/done_pulse", 64'(load_done), 64'(1));
    check("load/words", 64'(load_words), 64'(e_words));
    check("load/busy_done", 64'(busy), 64'(1));
    repeat (3) begin
      load_byte_valid = full ? 1'($urandom) : 1'b0;
      load_byte = 8'($urandom);
      @(negedge clk);
      check("load/done_end", 64'(load_done), 64'(0));
      check("load/busy_end", 64'(busy), 64'(0));
      check("load/words_hold", 64'(load_words), 64'(e_words));
    end
    load_byte_valid = 0;
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 32'h400 + ($urandom_range(0, 1023) << 2);
      1: return ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
      2: return $urandom;
      default: return $urandom_range(0, 255) << 2;
    endcase
  endfunction
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1;
    fetch_req = 0;
    fetch_stall = 0;
    fetch_addr = 0;
    load_en = 0;
    load_byte_valid = 0;
    load_byte = 0;
    e_instr = 0;
    e_valid = 0;
    e_err = 0;
    e_words = 0;
    repeat (2) @(negedge clk);
    check_outs("reset");
    check("reset/done", 64'(load_done), 64'(0));
    check("reset/words", 64'(load_words), 64'(0));
    check("reset/busy", 64'(busy), 64'(0));
    reset = 0;
    @(negedge clk);
    bq = '{8'h20, 8'h04, 8'h00, 8'h03, 8'h0c, 8'h00, 8'h00, 8'h03, 8'h10, 8'h00, 8'hff, 8'hff};
    run_load(0);
    cyc(1, 0, 32'h0);
    check("tp/w0", 64'(instr), 64'h20040003);
    cyc(1, 0, 32'h4);
    check("tp/w1", 64'(instr), 64'h0c000003);
    cyc(1, 0, 32'h8);
    check("tp/w2", 64'(instr), 64'h1000ffff);
    cyc(1, 0, 32'h400);
    check("tp/oor", 64'({fetch_err, instr}), 64'h1_0000_0000);
    cyc(1, 0, 32'h6);
    check("tp/misal", 64'({fetch_err, instr}), 64'h1_0000_0000);
    cyc(0, 0, 32'h0);
    cyc(1, 0, 32'h4);
    repeat (3) cyc(1, 1, 32'h8);
    check("tp/stall", 64'({instr_valid, instr}), 64'h1_0c000003);
    cyc(1, 0, 32'h8);
    check("tp/release", 64'(instr), 64'h1000ffff);
    cyc(0, 0, 32'h0);
    bq = '{8'h23, 8'hbd, 8'hff, 8'hf8, 8'haf, 8'hbf, 8'h00, 8'h04};
    run_load(1);
    check("tp/words2", 64'(load_words), 64'(2));
    cyc(1, 0, 32'h0);
    check("tp/ld0", 64'(instr), 64'h23bdfff8);
    cyc(1, 0, 32'h4);
    check("tp/ld1", 64'(instr), 64'hafbf0004);
    cyc(0, 0, 32'h0);
    bq = {};
    repeat (6) bq.push_back(8'($urandom));
    run_load(1);
    check("tp/partial_words", 64'(load_words), 64'(1));
    cyc(1, 0, 32'h4);
    check("tp/partial_keep", 64'(instr), 64'hafbf0004);
    cyc(1, 0, 32'h0);
    cyc(0, 0, 32'h0);
    bq = {};
    repeat (4 * DEPTH + 16) bq.push_back(8'($urandom));
    run_load(0);
    check("tp/full_words", 64'(load_words), 64'(DEPTH));
    repeat (8) cyc(1, 0, $urandom_range(0, 255) << 2);
    cyc(1, 0, 32'h3fc);
    cyc(0, 0, 32'h0);
    load_en = 0;
    cyc(0, 0, 32'h0);
    bq = {};
    run_load(0);
    fetch_addr = 0;
    fetch_req = 1;
    load_en = 1;
    @(negedge clk);
    e_valid = 0;
    e_err = 0;
    check("prio/busy", 64'(busy), 64'(1));
    check_outs("prio/enter");
    repeat (2) begin
      @(negedge clk);
      check_outs("prio/hold");
    end
    load_en = 0;
    fetch_req = 0;
    @(negedge clk);
    e_words = 0;
    check("prio/done", 64'(load_done), 64'(1));
    check("prio/words", 64'(load_words), 64'(0));
    @(negedge clk);
    check_outs("prio/after");
    check("prio/busy_end", 64'(busy), 64'(0));
    load_en = 1;
    @(negedge clk);
    e_valid = 0;
    e_err = 0;
    bq = {};
    repeat (5) bq.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      load_byte_valid = 1;
      load_byte = bq[i];
      @(negedge clk);
    end
    mm[0] = {bq[0], bq[1], bq[2], bq[3]};
    reset = 1;
    #1;
    e_instr = 0;
    e_words = 0;
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/words", 64'(load_words), 64'(0));
    check("rst/done", 64'(load_done), 64'(0));
    check_outs("rst");
    load_en = 0;
    load_byte_valid = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst/no_done", 64'(load_done), 64'(0));
    end
    cyc(1, 0, 32'h0);
    check("rst/kept", 64'(instr), 64'({bq[0], bq[1], bq[2], bq[3]}));
    cyc(0, 0, 32'h0);
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        bq = {};
        repeat ($urandom_range(0, 48)) bq.push_back(8'($urandom));
        run_load(1);
      end else begin
        repeat ($urandom_range(10, 30))
          cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rand_addr());
        cyc(0, 0, 32'h0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
